ram_arbiter: RTL and testbench

Downstream neighbour of the coherence controller; sits between the coherence data port plus the per-CPU icache fetch ports and the single RAM port.
- Arbitrates one request at a time onto ramREN/ramWEN/ramaddr/ramstore.
- Holds each grant until ramstate reports ACCESS, then returns load data and drops wait to the granted requester.
- Data (coherence) traffic has priority; icaches share round-robin; a starvation counter bounds how long fetches can be blocked.

---
 rtl/cpu_types_pkg.sv | 13 +
 rtl/ram_arb_pkg.sv | 17 +
 rtl/ram_arbiter_rr_select.sv | 31 +++
 rtl/ram_arbiter.sv | 164 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word and RAM handshake state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/ram_arb_pkg.sv
// Types and helpers for the RAM arbiter.
package ram_arb_pkg;

  import cpu_types_pkg::*;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

  // Width of a requester index; never below one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_select.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module rr_select
  import ram_arb_pkg::*;
#(
  parameter int unsigned N = 2,
  localparam int unsigned IdW = id_width(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IdW-1:0] ptr_i,
  output logic [IdW-1:0] idx_o,
  output logic           valid_o
);

  // Scan N slots starting from the pointer; the first hit wins.
  always_comb begin
    logic [IdW-1:0] j;
    logic           found;
    idx_o   = '0;
    valid_o = 1'b0;
    found   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      j = IdW'((32'(ptr_i) + i) % N);
      if (!found && req_i[j]) begin
        idx_o = j;
        found = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: coherence data port has priority over round-robin icache
// fetches, with a burst counter bounding fetch starvation.
// Optional statistics counters are built when RAM_ARB_STATS_EN is defined.
module ram_arbiter
  import cpu_types_pkg::*;
  import ram_arb_pkg::*;
#(
  parameter int unsigned CPUS           = 2,
  parameter int unsigned DATA_BURST_MAX = 4
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [CPUS-1:0]     iREN,
  input  word_t [CPUS-1:0]    iaddr,
  output logic [CPUS-1:0]     iwait,
  output word_t [CPUS-1:0]    iload,
  input  logic                cc_ramREN,
  input  logic                cc_ramWEN,
  input  word_t               cc_ramaddr,
  input  word_t               cc_ramstore,
  output logic                cc_ramwait,
  output word_t               cc_ramload,
  output logic                ramREN,
  output logic                ramWEN,
  output word_t               ramaddr,
  output word_t               ramstore,
  input  word_t               ramload,
  input  ramstate_t           ramstate
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [31:0]         stat_dgrants,
  output logic [31:0]         stat_igrants,
  output logic [31:0]         stat_stall
`endif
);

  localparam int unsigned IdW    = id_width(CPUS);
  localparam int unsigned BurstW = $clog2(DATA_BURST_MAX + 1);
  localparam logic [BurstW-1:0] BurstMax = BurstW'(DATA_BURST_MAX);

  arb_state_t        state_q, state_d;
  logic [IdW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]    grant_id_q, grant_id_d;
  logic [BurstW-1:0] burst_cnt_q, burst_cnt_d;

  logic [IdW-1:0] sel_idx;
  logic           sel_valid;
  logic           data_req, any_ireq, ram_ready;
  logic           d_done, i_done;

  assign data_req  = cc_ramREN | cc_ramWEN;
  assign any_ireq  = |iREN;
  assign ram_ready = (ramstate == ACCESS);

  rr_select #(
    .N (CPUS)
  ) u_rr_select (
    .req_i   (iREN),
    .ptr_i   (rr_ptr_q),
    .idx_o   (sel_idx),
    .valid_o (sel_valid)
  );

  // Arbiter state, round-robin pointer, grant owner and starvation counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Next-state arbitration and the RAM/requester muxing for the current grant.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    burst_cnt_d = burst_cnt_q;
    iwait       = '1;
    iload       = '0;
    cc_ramwait  = 1'b1;
    cc_ramload  = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    d_done      = 1'b0;
    i_done      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Data yields only once it has used up its burst while a fetch waits.
        if (data_req && !((burst_cnt_q == BurstMax) && any_ireq)) begin
          state_d = DGRANT;
        end else if (sel_valid) begin
          state_d    = IGRANT;
          grant_id_d = sel_idx;
        end
      end
      DGRANT: begin
        if (!data_req) begin
          state_d = IDLE;
        end else begin
          ramWEN     = cc_ramWEN;
          ramREN     = cc_ramREN & ~cc_ramWEN;
          ramaddr    = cc_ramaddr;
          ramstore   = cc_ramstore;
          cc_ramload = ramload;
          cc_ramwait = ~ram_ready;
          if (ram_ready) begin
            d_done  = 1'b1;
            state_d = IDLE;
            if (any_ireq && (burst_cnt_q != BurstMax)) burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end
      end
      IGRANT: begin
        if (!iREN[grant_id_q]) begin
          state_d = IDLE;
        end else begin
          ramREN            = 1'b1;
          ramaddr           = iaddr[grant_id_q];
          iload[grant_id_q] = ramload;
          iwait[grant_id_q] = ~ram_ready;
          if (ram_ready) begin
            i_done      = 1'b1;
            state_d     = IDLE;
            burst_cnt_d = '0;
            rr_ptr_d    = (grant_id_q == IdW'(CPUS - 1)) ? '0 : grant_id_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef RAM_ARB_STATS_EN
  logic [31:0] stat_dgrants_q, stat_igrants_q, stat_stall_q;

  // Free-running wrap-around event counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stat_dgrants_q <= '0;
      stat_igrants_q <= '0;
      stat_stall_q   <= '0;
    end else begin
      if (d_done) stat_dgrants_q <= stat_dgrants_q + 32'd1;
      if (i_done) stat_igrants_q <= stat_igrants_q + 32'd1;
      if ((state_q != IDLE) && !ram_ready) stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_dgrants = stat_dgrants_q;
  assign stat_igrants = stat_igrants_q;
  assign stat_stall   = stat_stall_q;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter (CPUS=2, DATA_BURST_MAX=4).
module tb_ram_arbiter;
  import cpu_types_pkg::*;
  import ram_arb_pkg::*;

  logic         CLK = 1'b0;
  logic         nRST;
  logic [1:0]   iREN;
  word_t [1:0]  iaddr;
  logic [1:0]   iwait;
  word_t [1:0]  iload;
  logic         cc_ramREN, cc_ramWEN, cc_ramwait;
  word_t        cc_ramaddr, cc_ramstore, cc_ramload;
  logic         ramREN, ramWEN;
  word_t        ramaddr, ramstore, ramload;
  ramstate_t    ramstate;
`ifdef RAM_ARB_STATS_EN
  logic [31:0]  stat_dgrants, stat_igrants, stat_stall;
`endif

  int errors = 0;
  int checks = 0;

  ram_arbiter #(
    .CPUS           (2),
    .DATA_BURST_MAX (4)
  ) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .iREN        (iREN),
    .iaddr       (iaddr),
    .iwait       (iwait),
    .iload       (iload),
    .cc_ramREN   (cc_ramREN),
    .cc_ramWEN   (cc_ramWEN),
    .cc_ramaddr  (cc_ramaddr),
    .cc_ramstore (cc_ramstore),
    .cc_ramwait  (cc_ramwait),
    .cc_ramload  (cc_ramload),
    .ramREN      (ramREN),
    .ramWEN      (ramWEN),
    .ramaddr     (ramaddr),
    .ramstore    (ramstore),
    .ramload     (ramload),
    .ramstate    (ramstate)
`ifdef RAM_ARB_STATS_EN
    ,
    .stat_dgrants (stat_dgrants),
    .stat_igrants (stat_igrants),
    .stat_stall   (stat_stall)
`endif
  );

  always #5 CLK = ~CLK;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    iREN = '0; cc_ramREN = 1'b0; cc_ramWEN = 1'b0;
    cc_ramaddr = '0; cc_ramstore = '0; ramload = '0; ramstate = FREE;
  endtask

  task automatic test_reset();
    idle_inputs();
    iaddr = '0;
    nRST = 1'b0;
    #3;
    checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin errors++;
      $display("FAIL reset_en ramREN=%b ramWEN=%b required 0 0", ramREN, ramWEN); end
    checks++; if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin errors++;
      $display("FAIL reset_bus ramaddr=%h ramstore=%h required 0 0", ramaddr, ramstore); end
    checks++; if (iwait !== 2'b11 || cc_ramwait !== 1'b1) begin errors++;
      $display("FAIL reset_wait iwait=%b cc_ramwait=%b required 11 1", iwait, cc_ramwait); end
    checks++; if (dut.state_q !== IDLE || dut.rr_ptr_q !== 1'b0 || dut.burst_cnt_q !== 3'd0) begin
      errors++; $display("FAIL reset_state state=%0d rr=%0d burst=%0d required 0 0 0",
                         dut.state_q, dut.rr_ptr_q, dut.burst_cnt_q); end
    tick();
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_single_fetch();
    iREN = 2'b01; iaddr[0] = 32'h100;
    #1;
    checks++; if (ramREN !== 1'b0) begin errors++;
      $display("FAIL fetch_bubble ramREN=%b required 0", ramREN); end
    tick();
    ramstate = BUSY;
    #1;
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h100 || iwait !== 2'b11) begin errors++;
      $display("FAIL fetch_grant ramREN=%b addr=%h iwait=%b required 1 100 11",
               ramREN, ramaddr, iwait); end
    tick();
    #1;
    checks++; if (iwait !== 2'b11) begin errors++;
      $display("FAIL fetch_busy iwait=%b required 11", iwait); end
    tick();
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    #1;
    checks++; if (iwait !== 2'b10 || iload[0] !== 32'hDEADBEEF) begin errors++;
      $display("FAIL fetch_done iwait=%b iload0=%h required 10 deadbeef", iwait, iload[0]); end
    tick();
    iREN = 2'b00; ramstate = FREE;
    #1;
    checks++; if (dut.state_q !== IDLE || iwait !== 2'b11 || ramREN !== 1'b0) begin errors++;
      $display("FAIL fetch_idle state=%0d iwait=%b ramREN=%b required 0 11 0",
               dut.state_q, iwait, ramREN); end
  endtask

  task automatic test_data_priority();
    tick();
    cc_ramWEN = 1'b1; cc_ramaddr = 32'h200; cc_ramstore = 32'h12345678;
    iREN = 2'b10; iaddr[1] = 32'h300;
    tick();
    ramstate = ACCESS;
    #1;
    checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h200 ||
                  ramstore !== 32'h12345678) begin errors++;
      $display("FAIL prio_write wen=%b ren=%b addr=%h store=%h required 1 0 200 12345678",
               ramWEN, ramREN, ramaddr, ramstore); end
    checks++; if (cc_ramwait !== 1'b0 || iwait !== 2'b11) begin errors++;
      $display("FAIL prio_wait cc_ramwait=%b iwait=%b required 0 11", cc_ramwait, iwait); end
    tick();
    cc_ramWEN = 1'b0; ramstate = FREE;
    #1;
    checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin errors++;
      $display("FAIL prio_bubble ren=%b wen=%b required 0 0", ramREN, ramWEN); end
    tick();
    ramstate = ACCESS; ramload = 32'hCAFE0001;
    #1;
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h300 || iwait !== 2'b01 ||
                  iload[1] !== 32'hCAFE0001 || iload[0] !== 32'h0) begin errors++;
      $display("FAIL prio_fetch ren=%b addr=%h iwait=%b iload1=%h iload0=%h req 1 300 01 cafe0001 0",
               ramREN, ramaddr, iwait, iload[1], iload[0]); end
    tick();
    iREN = 2'b00; ramstate = FREE;
  endtask

  task automatic test_round_robin();
    tick();
    iREN = 2'b11; iaddr[0] = 32'h400; iaddr[1] = 32'h500; ramstate = ACCESS;
    for (int k = 0; k < 4; k++) begin
      tick();
      #1;
      checks++;
      if (ramaddr !== ((k % 2 == 1) ? 32'h500 : 32'h400) ||
          iwait !== ((k % 2 == 1) ? 2'b01 : 2'b10)) begin errors++;
        $display("FAIL rr_order%0d addr=%h iwait=%b required %h %b", k, ramaddr, iwait,
                 (k % 2 == 1) ? 32'h500 : 32'h400, (k % 2 == 1) ? 2'b01 : 2'b10); end
      tick();
    end
    iREN = 2'b00; ramstate = FREE;
  endtask

  task automatic test_starvation();
    tick();
    cc_ramREN = 1'b1; cc_ramaddr = 32'h600; iREN = 2'b01; iaddr[0] = 32'h700;
    ramstate = ACCESS;
    for (int k = 0; k < 4; k++) begin
      tick();
      #1;
      checks++; if (ramaddr !== 32'h600 || cc_ramwait !== 1'b0 || iwait !== 2'b11) begin errors++;
        $display("FAIL starve_data%0d addr=%h cc_ramwait=%b iwait=%b required 600 0 11",
                 k, ramaddr, cc_ramwait, iwait); end
      tick();
    end
    tick();
    #1;
    checks++; if (ramaddr !== 32'h700 || iwait !== 2'b10 || cc_ramwait !== 1'b1) begin errors++;
      $display("FAIL starve_fetch addr=%h iwait=%b cc_ramwait=%b required 700 10 1",
               ramaddr, iwait, cc_ramwait); end
    tick();
    tick();
    #1;
    checks++; if (ramaddr !== 32'h600 || cc_ramwait !== 1'b0) begin errors++;
      $display("FAIL starve_resume addr=%h cc_ramwait=%b required 600 0", ramaddr, cc_ramwait); end
    tick();
    idle_inputs();
  endtask

  task automatic test_abandon();
    // Previous fetch went to CPU 0, so the pointer now favours CPU 1.
    tick();
    iREN = 2'b10; iaddr[1] = 32'h900; ramstate = BUSY;
    tick();
    #1;
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h900) begin errors++;
      $display("FAIL abandon_grant ren=%b addr=%h required 1 900", ramREN, ramaddr); end
    tick();
    iREN = 2'b00;
    #1;
    checks++; if (ramREN !== 1'b0 || iwait !== 2'b11) begin errors++;
      $display("FAIL abandon_drop ren=%b iwait=%b required 0 11", ramREN, iwait); end
    tick();
    checks++; if (dut.state_q !== IDLE || dut.rr_ptr_q !== 1'b1) begin errors++;
      $display("FAIL abandon_ptr state=%0d rr=%0d required 0 1", dut.state_q, dut.rr_ptr_q); end
    iREN = 2'b11; ramstate = ACCESS;
    tick();
    #1;
    checks++; if (iwait !== 2'b01 || ramaddr !== 32'h900) begin errors++;
      $display("FAIL abandon_next iwait=%b addr=%h required 01 900", iwait, ramaddr); end
    tick();
    idle_inputs();
  endtask

  task automatic test_async_reset();
    tick();
    cc_ramREN = 1'b1; cc_ramaddr = 32'hA00; ramstate = BUSY;
    tick();
    #1;
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'hA00) begin errors++;
      $display("FAIL areset_pre ren=%b addr=%h required 1 a00", ramREN, ramaddr); end
    #1;
    nRST = 1'b0;
    #1;
    checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== 32'h0 ||
                  cc_ramwait !== 1'b1 || iwait !== 2'b11) begin errors++;
      $display("FAIL areset_mid ren=%b wen=%b addr=%h ccwait=%b iwait=%b required 0 0 0 1 11",
               ramREN, ramWEN, ramaddr, cc_ramwait, iwait); end
    idle_inputs();
    tick();
    nRST = 1'b1;
  endtask

  task automatic test_both_enables();
    tick();
    cc_ramREN = 1'b1; cc_ramWEN = 1'b1; cc_ramaddr = 32'h800; cc_ramstore = 32'h55AA55AA;
    ramstate = ACCESS;
    tick();
    #1;
    checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'h55AA55AA ||
                  cc_ramwait !== 1'b0) begin errors++;
      $display("FAIL both_en wen=%b ren=%b store=%h ccwait=%b required 1 0 55aa55aa 0",
               ramWEN, ramREN, ramstore, cc_ramwait); end
    tick();
    idle_inputs();
`ifdef RAM_ARB_STATS_EN
    #1;
    checks++; if (stat_dgrants !== 32'd1 || stat_igrants !== 32'd0) begin errors++;
      $display("FAIL stats dgrants=%0d igrants=%0d required 1 0", stat_dgrants, stat_igrants); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_data_priority();
    test_round_robin();
    test_starvation();
    test_abandon();
    test_async_reset();
    test_both_enables();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
